mem_burst_scheduler: RTL
========================

// Module: mem_burst_scheduler
// PURPOSE
//  Decides which FIFO port the cellram transfer engine services next, and for how many bytes.
//  - 4 write slots (FIFO -> RAM) and 4 read slots (RAM -> FIFO) are scanned round-robin.
//  - Tracks per-port RAM occupancy and ring-buffer head/tail pointers.
//  - Issues one burst grant at a time (port, direction, start byte address, length) and waits for completion.
// PARAMETERS
//  NUM_PORTS    4   ports per direction; slots 0..NUM_PORTS-1 = write, NUM_PORTS..2*NUM_PORTS-1 = read
//  LVL_WIDTH    11  width of FIFO level/space fields
//  MAX_BURST    64  maximum grant length in bytes (>=1, <2**LVL_WIDTH)
//  REGION_LOG2  22  log2 bytes of the RAM ring region per port (4 ports x 4 MB = 16 MB cellram)
// PORTS
//  clk           in   1                     system clock
//  reset         in   1                     async, active-low; clears all state
//  enable        in   1                     1 = start new scans; 0 = finish current burst, then idle
//  write_levels  in   NUM_PORTS*LVL_WIDTH   bytes waiting in each write FIFO (port p at [p*W +: W])
//  read_spaces   in   NUM_PORTS*LVL_WIDTH   free bytes in each read FIFO
//  grant_valid   out  1                     burst grant offered
//  grant_ready   in   1                     engine accepts the grant this cycle
//  grant_dir     out  1                     1 = WRITING (FIFO->RAM), 0 = READING (RAM->FIFO)
//  grant_port    out  2                     port index
//  grant_addr    out  REGION_LOG2+2         byte address {port, ring pointer}
//  grant_len     out  LVL_WIDTH             burst length in bytes, 1..MAX_BURST
//  burst_done    in   1                     1-cycle pulse: granted burst fully transferred
//  busy          out  1                     grant outstanding (state GRANT or BUSY)
//  occupancies   out  NUM_PORTS*(REGION_LOG2+1)  bytes currently held in RAM per port
//  protocol_err  out  1                     sticky: burst_done seen outside BUSY
// BEHAVIOUR
//  Reset (async, reset=0): all outputs 0; occupancy, head and tail pointers 0; slot pointer 0; state IDLE.
//  FSM states:
//  - IDLE: go to SCAN when enable=1.
//  - SCAN: evaluate one slot per clk.
//    - Eligible -> latch grant fields, go to GRANT.
//    - Not eligible -> slot = slot+1 mod 2*NUM_PORTS.
//    - enable=0 in SCAN -> IDLE.
//  - GRANT: grant_valid=1; all grant_* fields held stable until grant_ready=1, then go to BUSY.
//  - BUSY: wait for burst_done. On burst_done:
//    - update pointers and occupancy;
//    - slot = granted slot+1 mod 2*NUM_PORTS;
//    - go to SCAN if enable=1, otherwise IDLE.
//  Eligibility and length (CAP = 2**REGION_LOG2):
//  - Write slot p:
//    - eligible iff write_levels[p]>0 and occ[p]<CAP;
//    - len = min(write_levels[p], MAX_BURST, CAP-occ[p]); addr = {p, head[p]}.
//  - Read slot p:
//    - eligible iff occ[p]>0 and read_spaces[p]>0;
//    - len = min(occ[p], read_spaces[p], MAX_BURST); addr = {p, tail[p]}.
//  - Inputs are sampled only in SCAN; later changes never alter a latched grant.
//  Completion updates (all mod CAP for pointers):
//  - Write burst: head[p] += len; occ[p] += len.
//  - Read burst: tail[p] += len; occ[p] -= len.
//  - The length rules guarantee occupancy never overflows CAP or underflows 0; no saturation logic.
//  Latency: an eligible slot found in SCAN cycle N gives grant_valid at cycle N+1.
//  Fairness: a slot granted once is not rescanned until the other 2*NUM_PORTS-1 slots have been scanned.
//  Scan order: w0..w3, r0..r3.
//  Boundary cases:
//  - No slot eligible -> continuous rescan, grant_valid stays 0.
//  - Pointer wrap at CAP: a burst may cross the wrap. The engine splits it using the addr low bits.
//  - burst_done while not BUSY: ignored for state; sets protocol_err.
//  - reset mid-burst: immediate return to reset state. RAM contents are logically discarded (occ=0).
//  - enable falling during GRANT/BUSY: the grant completes normally, then IDLE.
// STRUCTURE
//  - Package mem_sched_pkg: state encoding (IDLE, SCAN, GRANT, BUSY); DIR_READING=0 and DIR_WRITING=1;
//    slot-to-port/direction helper functions.
//  - Sub-module mem_sched_len_calc: combinational 3-input unsigned min, mixed widths, plus the eligibility flag.
//    Instanced once on the muxed current slot.
//  - Per-port head/tail/occ held in register arrays in the top.
// TESTING
//  1. Reset, enable=1, write_levels[2]=10, others 0:
//     grant w2, addr={2,0}, len=10; done -> occ[2]=10, head[2]=10.
//  2. Then read_spaces[2]=4:
//     grant r2, len=4, addr={2,0}; done -> occ[2]=6, tail[2]=4.
//  3. write_levels[0]=200, MAX_BURST=64:
//     grants of 64, 64, 64, 8 as levels drop. Other eligible slots are interleaved between them (round-robin).
//  4. REGION_LOG2=6, occ[1]=60, head[1]=60, write_levels[1]=10:
//     len=4, addr={1,60}; done -> head[1]=0, occ[1]=64.
//     The next w1 scan is ineligible until a read completes.
//  5. Hold grant_ready=0 for 5 cycles while write_levels changes:
//     grant fields stay stable; the grant is accepted on the first ready cycle.
//  6. Pulse burst_done in IDLE -> protocol_err=1 and state unchanged.
//     Assert reset during BUSY -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/mem_sched_pkg.sv
// Shared encodings and slot helpers for the cellram burst scheduler.
package mem_sched_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_GRANT = 2'd2;
  localparam logic [1:0] ST_BUSY  = 2'd3;

  localparam logic DIR_READING = 1'b0;
  localparam logic DIR_WRITING = 1'b1;

  // Slots 0..num_ports-1 are write slots, the rest are read slots.
  function automatic logic slot_is_write(input int unsigned slot, input int unsigned num_ports);
    return slot < num_ports;
  endfunction

  function automatic int unsigned slot_port(input int unsigned slot, input int unsigned num_ports);
    return (slot < num_ports) ? slot : slot - num_ports;
  endfunction

endpackage

// File: rtl/mem_sched_len_calc.sv
// Burst length and eligibility for one slot: unsigned 3-way min over mixed-width operands.
module mem_sched_len_calc #(
  parameter int LVL_WIDTH = 11,
  parameter int OCC_WIDTH = 23,
  parameter int MAX_BURST = 64
) (
  input  logic                 is_write,
  input  logic [LVL_WIDTH-1:0] level,
  input  logic [LVL_WIDTH-1:0] space,
  input  logic [OCC_WIDTH-1:0] occ,
  output logic                 eligible,
  output logic [LVL_WIDTH-1:0] len
);

  localparam int CW = (LVL_WIDTH > OCC_WIDTH) ? LVL_WIDTH : OCC_WIDTH;
  localparam logic [OCC_WIDTH-1:0] CAP = {1'b1, {(OCC_WIDTH-1){1'b0}}};

  logic [OCC_WIDTH-1:0] room;
  logic [CW-1:0]        a, b, c, m;

  // Writes are bounded by FIFO level and free ring space, reads by occupancy and FIFO space.
  always_comb begin
    room = CAP - occ;
    a    = is_write ? CW'(level) : CW'(space);
    b    = is_write ? CW'(room)  : CW'(occ);
    c    = CW'(MAX_BURST);
    m    = (a < b) ? a : b;
    m    = (m < c) ? m : c;
    len      = LVL_WIDTH'(m);
    eligible = (a != '0) && (b != '0);
  end

endmodule

// File: rtl/mem_burst_scheduler.sv
// Round-robin burst scheduler: picks the next FIFO port and length for the cellram engine.
module mem_burst_scheduler
  import mem_sched_pkg::*;
#(
  parameter int NUM_PORTS   = 4,
  parameter int LVL_WIDTH   = 11,
  parameter int MAX_BURST   = 64,
  parameter int REGION_LOG2 = 22,
  localparam int PORT_W     = $clog2(NUM_PORTS),
  localparam int OCC_W      = REGION_LOG2 + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [NUM_PORTS*LVL_WIDTH-1:0] write_levels,
  input  logic [NUM_PORTS*LVL_WIDTH-1:0] read_spaces,
  output logic                           grant_valid,
  input  logic                           grant_ready,
  output logic                           grant_dir,
  output logic [PORT_W-1:0]              grant_port,
  output logic [REGION_LOG2+PORT_W-1:0]  grant_addr,
  output logic [LVL_WIDTH-1:0]           grant_len,
  input  logic                           burst_done,
  output logic                           busy,
  output logic [NUM_PORTS*OCC_W-1:0]     occupancies,
  output logic                           protocol_err
);

  localparam int SLOTS  = 2 * NUM_PORTS;
  localparam int SLOT_W = $clog2(SLOTS);

  logic [1:0]             state;
  logic [SLOT_W-1:0]      slot;
  logic [REGION_LOG2-1:0] head [NUM_PORTS];
  logic [REGION_LOG2-1:0] tail [NUM_PORTS];
  logic [OCC_W-1:0]       occ  [NUM_PORTS];

  logic                          cur_write;
  logic [PORT_W-1:0]             cur_port;
  logic [LVL_WIDTH-1:0]          cur_level;
  logic [LVL_WIDTH-1:0]          cur_space;
  logic [OCC_W-1:0]              cur_occ;
  logic [REGION_LOG2+PORT_W-1:0] cur_addr;
  logic                          cur_eligible;
  logic [LVL_WIDTH-1:0]          cur_len;

  function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
    return (s == SLOT_W'(SLOTS - 1)) ? '0 : s + 1'b1;
  endfunction

  // NOTE: every signal written here gets a value on every path, so no latch is inferred.
  always_comb begin
    cur_write = slot_is_write(32'(slot), NUM_PORTS);
    cur_port  = PORT_W'(slot_port(32'(slot), NUM_PORTS));
    cur_level = write_levels[cur_port*LVL_WIDTH +: LVL_WIDTH];
    cur_space = read_spaces[cur_port*LVL_WIDTH +: LVL_WIDTH];
    cur_occ   = occ[cur_port];
    cur_addr  = {cur_port, cur_write ? head[cur_port] : tail[cur_port]};
  end

  mem_sched_len_calc #(
    .LVL_WIDTH (LVL_WIDTH),
    .OCC_WIDTH (OCC_W),
    .MAX_BURST (MAX_BURST)
  ) u_len_calc (
    .is_write (cur_write),
    .level    (cur_level),
    .space    (cur_space),
    .occ      (cur_occ),
    .eligible (cur_eligible),
    .len      (cur_len)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      slot         <= '0;
      grant_dir    <= DIR_READING;
      grant_port   <= '0;
      grant_addr   <= '0;
      grant_len    <= '0;
      protocol_err <= 1'b0;
      // NOTE: the pointer/occupancy arrays are small register files, so they take the async reset too.
      for (int p = 0; p < NUM_PORTS; p++) begin
        head[p] <= '0;
        tail[p] <= '0;
        occ[p]  <= '0;
      end
    end else begin
      if (burst_done && (state != ST_BUSY))
        protocol_err <= 1'b1;

      case (state)
        ST_IDLE: if (enable) state <= ST_SCAN;

        ST_SCAN: begin
          if (!enable) begin
            state <= ST_IDLE;
          end else if (cur_eligible) begin
            grant_dir  <= cur_write ? DIR_WRITING : DIR_READING;
            grant_port <= cur_port;
            grant_addr <= cur_addr;
            grant_len  <= cur_len;
            state      <= ST_GRANT;
          end else begin
            slot <= next_slot(slot);
          end
        end

        ST_GRANT: if (grant_ready) state <= ST_BUSY;

        ST_BUSY: begin
          if (burst_done) begin
            // Pointers wrap naturally at the region size; the length rules keep occ within 0..CAP.
            if (grant_dir == DIR_WRITING) begin
              head[grant_port] <= head[grant_port] + REGION_LOG2'(grant_len);
              occ[grant_port]  <= occ[grant_port] + OCC_W'(grant_len);
            end else begin
              tail[grant_port] <= tail[grant_port] + REGION_LOG2'(grant_len);
              occ[grant_port]  <= occ[grant_port] - OCC_W'(grant_len);
            end
            slot  <= next_slot(slot);
            state <= enable ? ST_SCAN : ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    grant_valid = (state == ST_GRANT);
    busy        = (state == ST_GRANT) || (state == ST_BUSY);
    occupancies = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      occupancies[p*OCC_W +: OCC_W] = occ[p];
  end

endmodule
